ytydla_cmac_accu_ctrl: RTL

- Sequences the 64-lane, 3-stage CMAC accumulation tree over one output element.
- Accepts K chunk beats from the CMAC array under a valid/ready handshake and drives the tree's input-valid.
- Tracks in-flight beats with a delay line matched to the tree latency.
- Sums the K returned tree results into one scalar and presents it downstream under valid/ready, with a done pulse.

---
 rtl/ytydla_pkg.sv | 16 +
 rtl/ytydla_vld_delay.sv | 24 ++
 rtl/ytydla_cmac_accu_ctrl.sv | 91 +++++++++
 3 files changed

// File: rtl/ytydla_pkg.sv
// Shared types and defaults for the ytydla CMAC datapath controllers.
package ytydla_pkg;

   localparam int YTYDLA_DATA_LENGTH = 32;

   typedef enum logic [1:0] {
      ACCU_CTRL_IDLE,
      ACCU_CTRL_FEED,
      ACCU_CTRL_DRAIN,
      ACCU_CTRL_OUT
   } cmac_accu_ctrl_fsm_e;

   // Registered depth of the 64-lane, 3-stage accumulation tree.
   localparam int CMAC_ACCU_TREE_LAT = 3;

endpackage

// File: rtl/ytydla_vld_delay.sv
// Valid-bit delay line that tracks beats in flight through a fixed-latency pipeline.
module ytydla_vld_delay #(
   parameter int DEPTH = 3
) (
   input  logic ytydla_core_clk,
   input  logic ytydla_core_rst,
   input  logic din,
   output logic dout
);

   logic [DEPTH-1:0] sr_q;

   // The shift form holds for DEPTH == 1, where a part-select would not.
   always_ff @(posedge ytydla_core_clk or posedge ytydla_core_rst) begin
      if (ytydla_core_rst) begin
         sr_q <= '0;
      end else begin
         sr_q <= (sr_q << 1) | DEPTH'(din);
      end
   end

   assign dout = sr_q[DEPTH-1];

endmodule

// File: rtl/ytydla_cmac_accu_ctrl.sv
// Sequences K chunk beats through the CMAC accumulation tree and sums the returns.
//   state | meaning
//   IDLE  | waiting for start; chunk count latched on accept
//   FEED  | accepting chunk beats into the tree
//   DRAIN | all beats issued, collecting tree returns
//   OUT   | final sum presented until downstream takes it
module ytydla_cmac_accu_ctrl
   import ytydla_pkg::*;
#(
   parameter int DATA_W   = YTYDLA_DATA_LENGTH,
   parameter int TREE_LAT = CMAC_ACCU_TREE_LAT,
   parameter int CNT_W    = 8
) (
   input  logic              ytydla_core_clk,
   input  logic              ytydla_core_rst,
   input  logic [CNT_W-1:0]  cfg_chunk_num,
   input  logic              start,
   output logic              busy,
   input  logic              src_valid,
   output logic              src_ready,
   output logic              tree_valid,
   input  logic [DATA_W-1:0] tree_result,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready,
   output logic              done
);

   cmac_accu_ctrl_fsm_e state_q, state_d;
   logic [CNT_W-1:0]    chunk_num_q, issue_cnt_q, ret_cnt_q;
   logic [DATA_W-1:0]   acc_q;
   logic                ret_vld, accept_start, last_issue, last_return;

   ytydla_vld_delay #(.DEPTH(TREE_LAT)) u_vld_delay (
      .ytydla_core_clk (ytydla_core_clk),
      .ytydla_core_rst (ytydla_core_rst),
      .din             (tree_valid),
      .dout            (ret_vld)
   );

   assign accept_start = (state_q == ACCU_CTRL_IDLE) && start;
   assign last_issue   = src_valid && (issue_cnt_q == chunk_num_q - CNT_W'(1));
   // A return landing this cycle counts, so OUT follows the final sample directly.
   assign last_return  = (ret_cnt_q == chunk_num_q)
                      || (ret_vld && ((ret_cnt_q + CNT_W'(1)) == chunk_num_q));

   assign busy       = (state_q != ACCU_CTRL_IDLE);
   assign src_ready  = (state_q == ACCU_CTRL_FEED);
   assign out_valid  = (state_q == ACCU_CTRL_OUT);
   assign tree_valid = src_valid & src_ready;
   assign done       = out_valid & out_ready;
   assign out_data   = out_valid ? acc_q : '0;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ACCU_CTRL_IDLE:  if (start)       state_d = ACCU_CTRL_FEED;
         ACCU_CTRL_FEED:  if (last_issue)  state_d = ACCU_CTRL_DRAIN;
         ACCU_CTRL_DRAIN: if (last_return) state_d = ACCU_CTRL_OUT;
         ACCU_CTRL_OUT:   if (out_ready)   state_d = ACCU_CTRL_IDLE;
         default:                          state_d = ACCU_CTRL_IDLE;
      endcase
   end

   always_ff @(posedge ytydla_core_clk or posedge ytydla_core_rst) begin
      if (ytydla_core_rst) begin
         state_q     <= ACCU_CTRL_IDLE;
         chunk_num_q <= '0;
         issue_cnt_q <= '0;
         ret_cnt_q   <= '0;
         acc_q       <= '0;
      end else begin
         state_q <= state_d;
         if (accept_start) begin
            chunk_num_q <= (cfg_chunk_num == '0) ? CNT_W'(1) : cfg_chunk_num;
            issue_cnt_q <= '0;
            ret_cnt_q   <= '0;
            acc_q       <= '0;
         end else begin
            if (tree_valid) begin
               issue_cnt_q <= issue_cnt_q + CNT_W'(1);
            end
            if (ret_vld) begin
               acc_q     <= acc_q + tree_result;
               ret_cnt_q <= ret_cnt_q + CNT_W'(1);
            end
         end
      end
   end

endmodule
